// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank load arbiter.
//   state_t  : arbiter FSM states
//   NUM_REQ  : number of requesters / bank registers
//   IDX_W    : width of a requester index
//   rr_next  : round-robin successor, (p + 1) mod NUM_REQ
package reg_bank_pkg;

    localparam int NUM_REQ = 3;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LOAD  = 2'd2,
        ACK   = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/reg_bank3.sv
// Three DW-bit bank registers fed from one shared source bus.
//   clk, rst_n : clock, synchronous active-low reset
//   d          : shared source bus
//   ld_en      : per-register load enable (one-hot or zero)
//   q0..q2     : register contents
module reg_bank3 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] d,
    input  logic [2:0]    ld_en,
    output logic [DW-1:0] q0,
    output logic [DW-1:0] q1,
    output logic [DW-1:0] q2
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q0 <= '0;
            q1 <= '0;
            q2 <= '0;
        end else begin
            if (ld_en[0]) q0 <= d;
            if (ld_en[1]) q1 <= d;
            if (ld_en[2]) q2 <= d;
        end
    end

endmodule

// File: rtl/reg_bank_load_arbiter.sv
// Round-robin load arbiter for a three-register bank sharing one data bus.
// A winner is chosen in IDLE, its data latched onto d, held SETUP_CYC cycles,
// strobed into its bank register (LOAD), then acknowledged (ACK).
//   clk, rst_n         : clock, synchronous active-low reset
//   req[2:0]           : per-requester load request
//   wdata0..2          : requester data, sampled in the grant cycle only
//   ack[2:0]           : one-cycle completion pulse
//   busy               : FSM not in IDLE
//   last_grant[1:0]    : index of most recently completed grant
//   d                  : shared bus into the bank
//   ld_en[2:0]         : one-hot bank load strobe
//   q0..q2             : bank register contents
module reg_bank_load_arbiter
    import reg_bank_pkg::*;
#(
    parameter int DW        = 8,
    parameter int SETUP_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    req,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    output logic [2:0]    ack,
    output logic          busy,
    output logic [1:0]    last_grant,
    output logic [DW-1:0] d,
    output logic [2:0]    ld_en,
    output logic [DW-1:0] q0,
    output logic [DW-1:0] q1,
    output logic [DW-1:0] q2
);

    // Terminal value of the setup counter; unused when SETUP_CYC is 0.
    localparam logic [3:0] SETUP_LAST = 4'((SETUP_CYC == 0) ? 0 : SETUP_CYC - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic [3:0]       cnt;

    // Round-robin search starting at ptr.
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
            idx = rr_next(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_en     = '0;
        ack       = '0;
        case (state)
            IDLE:  if (found) state_nxt = (SETUP_CYC > 0) ? SETUP : LOAD;
            SETUP: if (cnt == SETUP_LAST) state_nxt = LOAD;
            LOAD: begin
                ld_en[win] = 1'b1;
                state_nxt  = ACK;
            end
            ACK: begin
                ack[win]  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath: winner/data latch in IDLE, setup count, pointer update in ACK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d          <= '0;
            win        <= '0;
            ptr        <= '0;
            last_grant <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    win <= pick;
                    cnt <= '0;
                    case (pick)
                        2'd0:    d <= wdata0;
                        2'd1:    d <= wdata1;
                        default: d <= wdata2;
                    endcase
                end
                SETUP: cnt <= cnt + 4'd1;
                ACK: begin
                    last_grant <= win;
                    ptr        <= rr_next(win);
                end
                default: ;
            endcase
        end
    end

    reg_bank3 #(.DW(DW)) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .ld_en (ld_en),
        .q0    (q0),
        .q1    (q1),
        .q2    (q2)
    );

endmodule

// File: tb/tb_reg_bank_load_arbiter.sv
// Bench for reg_bank_load_arbiter: instance a uses SETUP_CYC=1, instance b
// uses SETUP_CYC=0. Table vectors, hand sequences and a randomized run
// against a transaction-level reference model.
module tb_reg_bank_load_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req_a, req_b;
    logic [7:0] wdata0, wdata1, wdata2;

    logic [2:0] ack_a, ld_a, ack_b, ld_b;
    logic       busy_a, busy_b;
    logic [1:0] lg_a, lg_b;
    logic [7:0] d_a, q0_a, q1_a, q2_a, d_b, q0_b, q1_b, q2_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank_load_arbiter #(.DW(8), .SETUP_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .ack(ack_a), .busy(busy_a), .last_grant(lg_a), .d(d_a), .ld_en(ld_a),
        .q0(q0_a), .q1(q1_a), .q2(q2_a)
    );

    reg_bank_load_arbiter #(.DW(8), .SETUP_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .ack(ack_b), .busy(busy_b), .last_grant(lg_b), .d(d_b), .ld_en(ld_b),
        .q0(q0_b), .q1(q1_b), .q2(q2_b)
    );

    typedef struct {
        logic [2:0] req;
        logic [7:0] w0, w1, w2;
        logic [2:0] e_ack;
        logic       e_busy;
        logic [1:0] e_lg;
        logic [7:0] e_d;
        logic [2:0] e_ld;
        logic [7:0] e_q0, e_q1, e_q2;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [2:0] r, logic [7:0] w0, logic [7:0] w1, logic [7:0] w2,
                                logic [2:0] a, logic b, logic [1:0] lg, logic [7:0] dd,
                                logic [2:0] ld, logic [7:0] e0, logic [7:0] e1, logic [7:0] e2);
        vec_t v;
        v.req = r; v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.e_ack = a; v.e_busy = b; v.e_lg = lg; v.e_d = dd; v.e_ld = ld;
        v.e_q0 = e0; v.e_q1 = e1; v.e_q2 = e2;
        return v;
    endfunction

    // Packed observation {ack, busy, last_grant, d, ld_en, q0, q1, q2}.
    function automatic logic [40:0] obs(int s);
        if (s == 1) return {ack_a, busy_a, lg_a, d_a, ld_a, q0_a, q1_a, q2_a};
        else        return {ack_b, busy_b, lg_b, d_b, ld_b, q0_b, q1_b, q2_b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    function automatic int oh2i(logic [2:0] oh);
        return oh[0] ? 0 : (oh[1] ? 1 : 2);
    endfunction

    // Randomized run against a transaction-level model: a grant in an idle
    // cycle starts a transfer whose phase p counts cycles since the grant;
    // load strobe at p=S+1, ack and register update at p=S+2, idle at p=S+3.
    task automatic run_rand(input int s, input int ncyc);
        int         S = (s == 1) ? 1 : 0;
        bit         active = 0;
        int         p = 0, w = 0, ptr = 0, lg = 0;
        logic [7:0] data = 0, md = 0;
        logic [7:0] mq[3] = '{0, 0, 0};
        logic [7:0] wd[3];
        logic [2:0] r, prev_ack = 0, e_ack, e_ld;
        logic       e_busy;
        do_reset;
        for (int c = 0; c < ncyc; c++) begin
            e_busy = active && p >= 1;
            e_ld   = (active && p == S + 1) ? 3'(1 << w) : 3'b000;
            e_ack  = (active && p == S + 2) ? 3'(1 << w) : 3'b000;
            chk($sformatf("rand_s%0d_c%0d", S, c), obs(s),
                {e_ack, e_busy, 2'(lg), md, e_ld, mq[0], mq[1], mq[2]});
            r = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            r = r & ~prev_ack;
            prev_ack = e_ack;
            for (int i = 0; i < 3; i++) wd[i] = 8'($urandom);
            wdata0 = wd[0]; wdata1 = wd[1]; wdata2 = wd[2];
            if (s == 1) begin req_a = r; req_b = '0; end
            else        begin req_b = r; req_a = '0; end
            if (!active && r != 0) begin
                for (int k = 2; k >= 0; k--)
                    if (r[(ptr + k) % 3]) w = (ptr + k) % 3;
                active = 1; p = 0; data = wd[w]; md = data;
            end
            tick;
            if (active) begin
                p++;
                if (p == S + 2) mq[w] = data;
                if (p == S + 3) begin
                    active = 0;
                    lg  = w;
                    ptr = (w + 1) % 3;
                end
            end
        end
        req_a = '0;
        req_b = '0;
    endtask

    initial begin
        int         n, pend, gap0, gap1, last_c;
        logic [2:0] order[4];
        int         acyc[4];

        rst_n = 1'b0; req_a = '0; req_b = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;
        do_reset;
        tick;
        chk("reset_b", obs(0), 41'd0);

        // --- Table vectors on instance a (SETUP_CYC=1) ---
        for (int i = 0; i < 10; i++)
            vt.push_back(mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 8'h00, 3'b000, 0, 0, 0));
        vt.push_back(mk(3'b010, 8'h00, 8'hFF, 8'h00, 3'b000, 1, 0, 8'hFF, 3'b000, 0, 0, 0));
        vt.push_back(mk(3'b000, 0, 0, 0, 3'b000, 1, 0, 8'hFF, 3'b010, 0, 0, 0));
        vt.push_back(mk(3'b000, 0, 0, 0, 3'b010, 1, 0, 8'hFF, 3'b000, 0, 8'hFF, 0));
        vt.push_back(mk(3'b000, 0, 0, 0, 3'b000, 0, 1, 8'hFF, 3'b000, 0, 8'hFF, 0));
        vt.push_back(mk(3'b000, 0, 0, 0, 3'b000, 0, 1, 8'hFF, 3'b000, 0, 8'hFF, 0));
        vt.push_back(mk(3'b001, 8'h5A, 8'h11, 8'h22, 3'b000, 1, 1, 8'h5A, 3'b000, 0, 8'hFF, 0));
        vt.push_back(mk(3'b000, 8'h77, 8'h77, 8'h77, 3'b000, 1, 1, 8'h5A, 3'b001, 0, 8'hFF, 0));
        vt.push_back(mk(3'b000, 0, 0, 0, 3'b001, 1, 1, 8'h5A, 3'b000, 8'h5A, 8'hFF, 0));
        vt.push_back(mk(3'b000, 0, 0, 0, 3'b000, 0, 0, 8'h5A, 3'b000, 8'h5A, 8'hFF, 0));

        foreach (vt[i]) begin
            req_a = vt[i].req;
            wdata0 = vt[i].w0; wdata1 = vt[i].w1; wdata2 = vt[i].w2;
            tick;
            chk($sformatf("vec%0d", i), obs(1),
                {vt[i].e_ack, vt[i].e_busy, vt[i].e_lg, vt[i].e_d, vt[i].e_ld,
                 vt[i].e_q0, vt[i].e_q1, vt[i].e_q2});
        end
        req_a = '0;

        // --- SETUP_CYC=0: single request on req[2] (instance b) ---
        wdata2 = 8'h3C;
        req_b  = 3'b100;
        tick;
        req_b  = 3'b000;
        wdata2 = 8'h00;
        chk("s0_ld_t1", {busy_b, ld_b, ack_b, d_b}, {1'b1, 3'b100, 3'b000, 8'h3C});
        tick;
        chk("s0_ack_t2", {busy_b, ld_b, ack_b, q2_b}, {1'b1, 3'b000, 3'b100, 8'h3C});
        tick;
        chk("s0_idle_t3", {busy_b, lg_b, q0_b, q1_b}, {1'b0, 2'd2, 8'h00, 8'h00});

        // --- Round robin with req=111 held (instance a) ---
        do_reset;
        wdata0 = 8'h01; wdata1 = 8'hAA; wdata2 = 8'h55;
        req_a = 3'b111;
        n = 0; pend = -1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick;
            if (pend >= 0) begin
                chk("rr_last_grant", lg_a, pend);
                pend = -1;
            end
            if (ack_a != 3'b000) begin
                order[n] = ack_a;
                acyc[n]  = c;
                pend     = oh2i(ack_a);
                n++;
                if (n == 4) req_a = 3'b000;
            end
        end
        chk("rr_count", n, 4);
        tick;
        if (pend >= 0) chk("rr_last_grant", lg_a, pend);
        if (n == 4) begin
            chk("rr_order", {order[0], order[1], order[2], order[3]},
                {3'b001, 3'b010, 3'b100, 3'b001});
            gap0 = acyc[1] - acyc[0];
            gap1 = acyc[3] - acyc[2];
            chk("rr_gap01", gap0, 4);
            chk("rr_gap23", gap1, 4);
        end
        chk("rr_q", {q0_a, q1_a, q2_a}, {8'h01, 8'hAA, 8'h55});
        chk("rr_idle", busy_a, 1'b0);

        // --- Reset during SETUP (instance a); ptr is 1 beforehand ---
        wdata0 = 8'hAA;
        req_a = 3'b001;
        tick;
        req_a = 3'b000;
        tick;
        tick;
        chk("rst_preload", {ack_a, q0_a}, {3'b001, 8'hAA});
        tick;
        wdata1 = 8'h77;
        req_a = 3'b010;
        tick;
        req_a = 3'b000;
        chk("rst_in_setup", {busy_a, ld_a, d_a}, {1'b1, 3'b000, 8'h77});
        rst_n = 1'b0;
        tick;
        chk("rst_mid", obs(1), 41'd0);
        rst_n = 1'b1;
        tick;
        chk("rst_after", obs(1), 41'd0);
        wdata0 = 8'h11; wdata1 = 8'h22; wdata2 = 8'h33;
        req_a = 3'b111;
        tick;
        req_a = 3'b000;
        chk("rst_ptr0_d", {busy_a, d_a}, {1'b1, 8'h11});
        tick;
        tick;
        chk("rst_ptr0_ack", {ack_a, q0_a}, {3'b001, 8'h11});
        tick;

        // --- req[0] arriving while a req[2] transfer is busy ---
        wdata2 = 8'hC3;
        req_a = 3'b100;
        tick;
        wdata0 = 8'h3E; wdata2 = 8'h00;
        req_a = 3'b001;
        chk("q_busy2", busy_a, 1'b1);
        tick;
        chk("q_ld2", ld_a, 3'b100);
        tick;
        chk("q_ack2", {ack_a, q2_a}, {3'b100, 8'hC3});
        tick;
        chk("q_idle_gap", {busy_a, ack_a}, {1'b0, 3'b000});
        tick;
        chk("q_grant0", {busy_a, d_a}, {1'b1, 8'h3E});
        tick;
        req_a = 3'b000;
        chk("q_ld0", ld_a, 3'b001);
        tick;
        chk("q_ack0", {ack_a, q0_a, q2_a}, {3'b001, 8'h3E, 8'hC3});
        tick;

        // --- Randomized runs against the reference model ---
        run_rand(1, 300);
        run_rand(0, 300);

        last_c = checks;
        $display("CHECKS %0d ERRORS %0d", last_c, errors);
        $finish;
    end

endmodule
